// File: rtl/stutter_pkg.sv
// Shared types and constants for the programmable stutter tick generator.
package stutter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/stutter_cnt_core.sv
// Count register with explicit wrap at the terminal value; clear beats advance.
module stutter_cnt_core
    import stutter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             adv,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;

    assign hit   = (count_r == term);
    assign count = count_r;

    // Next count: clear, wrap at terminal, increment, or hold.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {WIDTH{1'b0}};
        end else if (adv) begin
            if (hit) begin
                count_nxt_s = {WIDTH{1'b0}};
            end else begin
                count_nxt_s = count_r + WIDTH'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/stutter_prog.sv
// Programmable terminal-count tick generator: periodic/one-shot, start/stop,
// runtime term load and carry-in for cascading.
module stutter_prog
    import stutter_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TERM_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cin,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             cy,
    output logic             busy,
    output logic             done
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] term_r;
    logic             adv_s;
    logic             ctrl_s;
    logic             hit_s;
    logic             event_s;

    // Any control pulse clears the count and masks the terminal event.
    assign ctrl_s  = load | stop | start;
    assign adv_s   = (state_r == RUN) & en & cin;
    assign event_s = adv_s & hit_s & ~ctrl_s;
    assign cy      = event_s;
    assign busy    = (state_r == RUN);
    assign done    = (state_r == DONE);

    stutter_cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (ctrl_s),
        .adv   (adv_s),
        .term  (term_r),
        .count (count),
        .hit   (hit_s)
    );

    // Next state: stop beats start beats the terminal event.
    always_comb begin
        state_nxt_s = state_r;
        if (stop) begin
            state_nxt_s = IDLE;
        end else if (start) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = IDLE;
                RUN:     state_nxt_s = (event_s && (mode == MODE_ONESHOT)) ? DONE : RUN;
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Terminal-count register, reloaded only by load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            term_r <= TERM_RST;
        end else if (load) begin
            term_r <= load_val;
        end else begin
            term_r <= term_r;
        end
    end

endmodule

// File: tb/tb_stutter_prog.sv
// Randomised and directed bench for stutter_prog against an arithmetic model.
module tb_stutter_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, cin, mode, start, stop, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       cy, busy, done;

    // cascade pair
    logic       c_start, c_load;
    logic [3:0] c_val;
    logic [3:0] a_count, b_count;
    logic       a_cy, b_cy, a_busy, b_busy, a_done, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    // model: st 0=idle 1=run 2=done
    int m_st, m_cnt, m_term;

    always #5 clk = ~clk;

    stutter_prog #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .cin(cin), .mode(mode),
        .start(start), .stop(stop), .load(load), .load_val(load_val),
        .count(count), .cy(cy), .busy(busy), .done(done)
    );

    stutter_prog #(.WIDTH(4)) u_a (
        .clk(clk), .reset(reset), .en(1'b1), .cin(1'b1), .mode(1'b0),
        .start(c_start), .stop(1'b0), .load(c_load), .load_val(c_val),
        .count(a_count), .cy(a_cy), .busy(a_busy), .done(a_done)
    );

    stutter_prog #(.WIDTH(4)) u_b (
        .clk(clk), .reset(reset), .en(1'b1), .cin(a_cy), .mode(1'b0),
        .start(c_start), .stop(1'b0), .load(c_load), .load_val(c_val),
        .count(b_count), .cy(b_cy), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_term = 15;
    endtask

    // One clock: drive, check pre-edge outputs against the model, advance model.
    task automatic cyc(input logic e, input logic c, input logic m, input logic st,
                       input logic sp, input logic ld, input logic [3:0] lv);
        int exp_cy;
        @(negedge clk);
        en = e; cin = c; mode = m; start = st; stop = sp; load = ld; load_val = lv;
        #1;
        exp_cy = (m_st == 1 && e && c && m_cnt == m_term && !ld && !sp && !st) ? 1 : 0;
        check("count", 32'(count), 32'(m_cnt));
        check("busy", 32'(busy), (m_st == 1) ? 32'd1 : 32'd0);
        check("done", 32'(done), (m_st == 2) ? 32'd1 : 32'd0);
        check("cy", 32'(cy), 32'(exp_cy));
        @(posedge clk);
        if (ld || sp || st) m_cnt = 0;
        else if (m_st == 1 && e && c) m_cnt = (m_cnt + 1) % (m_term + 1);
        if (ld) m_term = int'(lv);
        if (sp) m_st = 0;
        else if (st) m_st = 1;
        else if (exp_cy == 1 && m) m_st = 2;
    endtask

    initial begin
        int last_b, n_b, cyc_i;
        reset = 1'b0;
        en = 1'b0; cin = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0;
        load = 1'b0; load_val = 4'd0;
        c_start = 1'b0; c_load = 1'b0; c_val = 4'd0;
        model_reset();
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cy", 32'(cy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // periodic, term 3
        cyc(1, 1, 0, 0, 0, 1, 4'd3);
        cyc(1, 1, 0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 4'd0);
            #1;
            check("per_seq", 32'(count), 32'((i + 1) % 4));
        end

        // one-shot, term 2
        cyc(1, 1, 1, 0, 0, 1, 4'd2);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(1, 1, 1, 0, 0, 0, 4'd0);
        #1;
        check("os_done", 32'(done), 32'd1);
        check("os_busy", 32'(busy), 32'd0);
        check("os_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 4'd0);
        cyc(1, 1, 1, 1, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0, 4'd0);

        // en gating at term 5
        cyc(1, 1, 0, 0, 0, 1, 4'd5);
        cyc(1, 1, 0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 4'd0);
        cyc(1, 1, 0, 0, 0, 0, 4'd0);

        // priority: load+stop+start at count 4
        cyc(1, 1, 0, 0, 0, 1, 4'd9);
        cyc(1, 1, 0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0);
        cyc(1, 1, 0, 1, 1, 1, 4'd7);
        #1;
        check("pri_count", 32'(count), 32'd0);
        check("pri_busy", 32'(busy), 32'd0);
        cyc(1, 1, 0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0);

        // term 0: divide by one
        cyc(1, 1, 0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0);

        // async reset mid-count
        cyc(1, 1, 0, 0, 0, 1, 4'd9);
        cyc(1, 1, 0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cy", 32'(cy), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 1, 0, 1, 0, 0, 4'd0);
        for (int i = 0; i < 17; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0);

        // random
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 6) != 0, ($urandom % 4) == 0,
                ($urandom % 25) == 0, ($urandom % 50) == 0, ($urandom % 40) == 0,
                4'($urandom % 8));
        end

        // cascade: both term 3, second cy every 16 clocks
        @(negedge clk);
        c_load = 1'b1; c_val = 4'd3;
        @(negedge clk);
        c_load = 1'b0; c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        last_b = -1; n_b = 0; cyc_i = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (b_cy) begin
                if (last_b < 0) check("casc_first", 32'(i), 32'd15);
                else check("casc_gap", 32'(i - last_b), 32'd16);
                last_b = i;
                n_b++;
            end
            @(negedge clk);
        end
        check("casc_pulses", 32'(n_b), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
